sm83_opfetch: RTL and testbench

Opcode fetch and instruction-state sequencer for the SM83 core. It produces the opcode stream consumed by `sm83_decode`: `opcode`, `bank_cb`, `in_halt` and `in_alu`. It latches fetched bytes into the instruction register and tracks the CB-prefix bank, HALT (including the HALT bug) and interrupt-dispatch pseudo-instructions. It also counts M-cycles within the current instruction. It sits between the memory read path and the decoder/sequencer.

---
 rtl/sm83_pkg.sv | 18 +
 rtl/sm83_opfetch_if.sv | 31 +++
 rtl/sm83_opfetch.sv | 110 +++++++++++
 tb/tb_sm83_opfetch.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm83_pkg.sv
// Shared SM83 core definitions: word size, opcode-fetch sequencer states
// and the opcode constants the fetch path needs to recognise.
package sm83_pkg;

    localparam int unsigned WORD_SIZE = 8;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        CB   = 2'd1,
        HALT = 2'd2,
        INT  = 2'd3
    } sm83_fetch_state_t;

    localparam logic [WORD_SIZE-1:0] OPC_NOP       = 8'h00;
    localparam logic [WORD_SIZE-1:0] OPC_PREFIX_CB = 8'hCB;
    localparam logic [WORD_SIZE-1:0] OPC_HALT      = 8'h76;

endpackage

// File: rtl/sm83_opfetch_if.sv
// Bundle between the memory read path / sequencer (master) and the opcode
// fetch block (slave).
interface sm83_opfetch_if;
    import sm83_pkg::*;

    logic                 mcyc_adv;
    logic                 fetch;
    logic [WORD_SIZE-1:0] rdata;
    logic                 halt_exec;
    logic                 ime;
    logic                 irq;

    logic [WORD_SIZE-1:0] opcode;
    logic                 bank_cb;
    logic                 in_halt;
    logic                 in_int;
    logic                 in_alu;
    logic [2:0]           mcyc;
    logic                 pc_inc;

    modport master (
        output mcyc_adv, fetch, rdata, halt_exec, ime, irq,
        input  opcode, bank_cb, in_halt, in_int, in_alu, mcyc, pc_inc
    );

    modport slave (
        input  mcyc_adv, fetch, rdata, halt_exec, ime, irq,
        output opcode, bank_cb, in_halt, in_int, in_alu, mcyc, pc_inc
    );

endinterface

// File: rtl/sm83_opfetch.sv
// SM83 opcode fetch / instruction-state sequencer: instruction register,
// CB bank, HALT (with HALT bug), interrupt dispatch and M-cycle counter.
module sm83_opfetch
    import sm83_pkg::*;
(
    input  logic          clk,
    input  logic          nreset,
    sm83_opfetch_if.slave bus
);

    sm83_fetch_state_t    state_q, state_d;
    logic [WORD_SIZE-1:0] opcode_q, opcode_d;
    logic                 bank_cb_q, bank_cb_d;
    logic [2:0]           mcyc_q, mcyc_d;
    logic                 pc_inc_q, pc_inc_d;
    logic                 bug_q, bug_d;
    logic                 take_int;

    assign take_int = (state_q == RUN) && bus.ime && bus.irq;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= RUN;
            opcode_q  <= OPC_NOP;
            bank_cb_q <= 1'b0;
            mcyc_q    <= '0;
            pc_inc_q  <= 1'b1;
            bug_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            bank_cb_q <= bank_cb_d;
            mcyc_q    <= mcyc_d;
            pc_inc_q  <= pc_inc_d;
            bug_q     <= bug_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.mcyc_adv) begin
            unique case (state_q)
                RUN: begin
                    if (bus.halt_exec) begin
                        // irq pending with IME clear is the HALT bug: no halt
                        if (!(bus.irq && !bus.ime)) state_d = HALT;
                    end else if (bus.fetch) begin
                        if (take_int)                          state_d = INT;
                        else if (bus.rdata == OPC_PREFIX_CB)   state_d = CB;
                    end
                end
                CB:      if (bus.fetch) state_d = RUN;
                HALT:    if (bus.irq)   state_d = RUN;
                INT:     if (bus.fetch) state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        opcode_d  = opcode_q;
        bank_cb_d = bank_cb_q;
        mcyc_d    = mcyc_q;
        pc_inc_d  = pc_inc_q;
        bug_d     = bug_q;
        if (bus.mcyc_adv) begin
            if (state_q == RUN && bus.halt_exec) begin
                pc_inc_d = 1'b0;
                if (bus.irq && !bus.ime) bug_d  = 1'b1;
                else                     mcyc_d = '0;
            end else if (state_q == HALT) begin
                mcyc_d = '0;
                if (bus.irq) pc_inc_d = 1'b1;
            end else if (bus.fetch) begin
                // bug flag clears on this fetch, so PC resumes incrementing
                mcyc_d   = '0;
                bug_d    = 1'b0;
                pc_inc_d = 1'b1;
                if (take_int) begin
                    opcode_d  = OPC_NOP;
                    bank_cb_d = 1'b0;
                    pc_inc_d  = 1'b0;
                end else begin
                    opcode_d  = bus.rdata;
                    bank_cb_d = (state_q == CB);
                end
            end else if (mcyc_q != 3'd7) begin
                mcyc_d = mcyc_q + 3'd1;
            end
        end
    end

    always_comb begin
        bus.in_alu = 1'b0;
        if (state_q == RUN && !bank_cb_q) begin
            if (opcode_q[7:6] == 2'b10 && opcode_q[2:0] != 3'b110 && mcyc_q == 3'd0)
                bus.in_alu = 1'b1;
            else if (opcode_q[7] && opcode_q[2:0] == 3'b110 && mcyc_q == 3'd1)
                bus.in_alu = 1'b1;
        end
    end

    assign bus.opcode  = opcode_q;
    assign bus.bank_cb = bank_cb_q;
    assign bus.in_halt = (state_q == HALT);
    assign bus.in_int  = (state_q == INT);
    assign bus.mcyc    = mcyc_q;
    assign bus.pc_inc  = pc_inc_q;

endmodule

// File: tb/tb_sm83_opfetch.sv
// Self-checking bench for sm83_opfetch: directed scenarios plus randomized
// strobes checked against a behavioural model of the fetch rules.
module tb_sm83_opfetch;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    sm83_opfetch_if bus();

    sm83_opfetch dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    localparam int M_RUN = 0, M_CB = 1, M_HALT = 2, M_INT = 3;
    int m_mode, m_op, m_mcyc;
    bit m_cb, m_pc, m_bug;

    task automatic model_reset();
        m_mode = M_RUN; m_op = 0; m_mcyc = 0; m_cb = 0; m_pc = 1; m_bug = 0;
    endtask

    task automatic model_step(input bit f, input int d, input bit h, input bit ie, input bit iq);
        if (h && m_mode == M_RUN) begin
            m_pc = 0;
            if (iq && !ie) m_bug = 1;
            else begin m_mode = M_HALT; m_mcyc = 0; end
        end else if (m_mode == M_HALT) begin
            if (iq) begin m_mode = M_RUN; m_pc = 1; end
        end else if (f) begin
            m_mcyc = 0; m_bug = 0; m_pc = 1;
            if (m_mode == M_RUN && ie && iq) begin
                m_mode = M_INT; m_op = 0; m_cb = 0; m_pc = 0;
            end else begin
                m_cb   = (m_mode == M_CB);
                m_op   = d;
                m_mode = (m_mode == M_RUN && d == 203) ? M_CB : M_RUN;
            end
        end else if (m_mcyc < 7) begin
            m_mcyc = m_mcyc + 1;
        end
    endtask

    function automatic logic [15:0] exp_vec();
        bit alu;
        alu = (m_mode == M_RUN) && !m_cb &&
              ((m_op / 64 == 2 && m_op % 8 != 6 && m_mcyc == 0) ||
               (m_op >= 128 && m_op % 8 == 6 && m_mcyc == 1));
        return {8'(m_op), m_cb, (m_mode == M_HALT), (m_mode == M_INT), alu, 3'(m_mcyc), m_pc};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {bus.opcode, bus.bank_cb, bus.in_halt, bus.in_int, bus.in_alu, bus.mcyc, bus.pc_inc};
    endfunction

    task automatic clear_inputs();
        bus.mcyc_adv = 0; bus.fetch = 0; bus.rdata = '0;
        bus.halt_exec = 0; bus.ime = 0; bus.irq = 0;
    endtask

    task automatic adv(input bit f, input logic [7:0] d, input bit h, input bit ie, input bit iq);
        @(negedge clk);
        bus.mcyc_adv = 1; bus.fetch = f; bus.rdata = d;
        bus.halt_exec = h; bus.ime = ie; bus.irq = iq;
        @(posedge clk);
        #1;
        clear_inputs();
        model_step(f, int'(d), h, ie, iq);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.mcyc_adv = 0; bus.fetch = 1'($urandom); bus.rdata = 8'($urandom);
        bus.halt_exec = 1'($urandom); bus.ime = 1'($urandom); bus.irq = 1'($urandom);
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic apply_reset();
        nreset = 0;
        model_reset();
        repeat (2) @(negedge clk);
        nreset = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (dut_vec() !== 16'h0001) begin
            n_errors++;
            $display("FAIL reset_state: got %h expected 0001", dut_vec());
        end
    endtask

    task automatic test_alu();
        adv(1, 8'h80, 0, 0, 0);
        n_checks++;
        if (bus.opcode !== 8'h80 || bus.bank_cb !== 0 || bus.mcyc !== 0 || bus.in_alu !== 1) begin
            n_errors++;
            $display("FAIL alu_reg: got op=%h cb=%b mcyc=%0d alu=%b expected op=80 cb=0 mcyc=0 alu=1",
                     bus.opcode, bus.bank_cb, bus.mcyc, bus.in_alu);
        end
        adv(1, 8'h86, 0, 0, 0);
        n_checks++;
        if (bus.in_alu !== 0) begin
            n_errors++; $display("FAIL alu_hl_m0: got %b expected 0", bus.in_alu);
        end
        adv(0, 8'h00, 0, 0, 0);
        n_checks++;
        if (bus.in_alu !== 1 || bus.mcyc !== 1) begin
            n_errors++; $display("FAIL alu_hl_m1: got alu=%b mcyc=%0d expected alu=1 mcyc=1", bus.in_alu, bus.mcyc);
        end
    endtask

    task automatic test_cb();
        adv(1, 8'hCB, 0, 0, 0);
        n_checks++;
        if (bus.opcode !== 8'hCB || bus.bank_cb !== 0) begin
            n_errors++; $display("FAIL cb_prefix: got op=%h cb=%b expected op=cb cb=0", bus.opcode, bus.bank_cb);
        end
        adv(1, 8'h7E, 0, 0, 0);
        n_checks++;
        if (bus.opcode !== 8'h7E || bus.bank_cb !== 1 || bus.in_alu !== 0) begin
            n_errors++;
            $display("FAIL cb_opcode: got op=%h cb=%b alu=%b expected op=7e cb=1 alu=0", bus.opcode, bus.bank_cb, bus.in_alu);
        end
        adv(1, 8'hCB, 0, 0, 0);
        adv(1, 8'h46, 0, 1, 1);
        n_checks++;
        if (bus.in_int !== 0 || bus.opcode !== 8'h46 || bus.bank_cb !== 1) begin
            n_errors++;
            $display("FAIL cb_no_int: got int=%b op=%h cb=%b expected int=0 op=46 cb=1", bus.in_int, bus.opcode, bus.bank_cb);
        end
        adv(1, 8'h12, 0, 1, 1);
        n_checks++;
        if (bus.in_int !== 1 || bus.opcode !== 8'h00 || bus.bank_cb !== 0) begin
            n_errors++;
            $display("FAIL cb_then_int: got int=%b op=%h cb=%b expected int=1 op=00 cb=0", bus.in_int, bus.opcode, bus.bank_cb);
        end
        adv(1, 8'hC9, 0, 0, 0);
    endtask

    task automatic test_int();
        adv(1, 8'h3C, 0, 1, 1);
        n_checks++;
        if (bus.in_int !== 1 || bus.opcode !== 8'h00 || bus.pc_inc !== 0) begin
            n_errors++;
            $display("FAIL int_entry: got int=%b op=%h pc_inc=%b expected int=1 op=00 pc_inc=0", bus.in_int, bus.opcode, bus.pc_inc);
        end
        repeat (4) adv(0, 8'h00, 0, 1, 1);
        n_checks++;
        if (bus.mcyc !== 3'd4 || bus.in_alu !== 0) begin
            n_errors++; $display("FAIL int_mcyc: got mcyc=%0d alu=%b expected mcyc=4 alu=0", bus.mcyc, bus.in_alu);
        end
        repeat (5) adv(0, 8'h00, 0, 0, 0);
        n_checks++;
        if (bus.mcyc !== 3'd7) begin
            n_errors++; $display("FAIL mcyc_saturate: got %0d expected 7", bus.mcyc);
        end
        adv(1, 8'hC9, 0, 0, 0);
        n_checks++;
        if (bus.in_int !== 0 || bus.opcode !== 8'hC9 || bus.pc_inc !== 1 || bus.mcyc !== 0) begin
            n_errors++;
            $display("FAIL int_exit: got int=%b op=%h pc_inc=%b mcyc=%0d expected int=0 op=c9 pc_inc=1 mcyc=0",
                     bus.in_int, bus.opcode, bus.pc_inc, bus.mcyc);
        end
    endtask

    task automatic test_halt();
        adv(1, 8'h76, 0, 0, 0);
        adv(0, 8'h00, 1, 0, 0);
        n_checks++;
        if (bus.in_halt !== 1 || bus.pc_inc !== 0 || bus.opcode !== 8'h76) begin
            n_errors++;
            $display("FAIL halt_entry: got halt=%b pc_inc=%b op=%h expected halt=1 pc_inc=0 op=76", bus.in_halt, bus.pc_inc, bus.opcode);
        end
        for (int i = 0; i < 10; i++) adv(1'(i % 2), 8'h55, 1'(i == 3), 1, 0);
        n_checks++;
        if (bus.in_halt !== 1 || bus.mcyc !== 0 || bus.opcode !== 8'h76) begin
            n_errors++;
            $display("FAIL halt_hold: got halt=%b mcyc=%0d op=%h expected halt=1 mcyc=0 op=76", bus.in_halt, bus.mcyc, bus.opcode);
        end
        adv(0, 8'h00, 0, 0, 1);
        n_checks++;
        if (bus.in_halt !== 0 || bus.pc_inc !== 1 || bus.in_int !== 0) begin
            n_errors++;
            $display("FAIL halt_wake: got halt=%b pc_inc=%b int=%b expected halt=0 pc_inc=1 int=0", bus.in_halt, bus.pc_inc, bus.in_int);
        end
    endtask

    task automatic test_halt_bug();
        adv(1, 8'h76, 0, 0, 0);
        adv(0, 8'h00, 1, 0, 1);
        n_checks++;
        if (bus.in_halt !== 0 || bus.pc_inc !== 0 || bus.opcode !== 8'h76) begin
            n_errors++;
            $display("FAIL haltbug_entry: got halt=%b pc_inc=%b op=%h expected halt=0 pc_inc=0 op=76", bus.in_halt, bus.pc_inc, bus.opcode);
        end
        adv(1, 8'h04, 0, 0, 0);
        n_checks++;
        if (bus.pc_inc !== 1 || bus.opcode !== 8'h04) begin
            n_errors++; $display("FAIL haltbug_fetch: got pc_inc=%b op=%h expected pc_inc=1 op=04", bus.pc_inc, bus.opcode);
        end
        adv(0, 8'h00, 0, 0, 0);
        n_checks++;
        if (bus.pc_inc !== 1 || bus.mcyc !== 1) begin
            n_errors++; $display("FAIL haltbug_clear: got pc_inc=%b mcyc=%0d expected pc_inc=1 mcyc=1", bus.pc_inc, bus.mcyc);
        end
    endtask

    task automatic test_async_reset();
        adv(1, 8'h00, 0, 1, 1);
        adv(0, 8'h00, 0, 0, 0);
        #2 nreset = 0;
        #1;
        n_checks++;
        if (dut_vec() !== 16'h0001) begin
            n_errors++; $display("FAIL areset_int: got %h expected 0001", dut_vec());
        end
        model_reset();
        @(negedge clk); nreset = 1;
        adv(1, 8'h76, 0, 0, 0);
        adv(0, 8'h00, 1, 0, 0);
        #2 nreset = 0;
        #1;
        n_checks++;
        if (dut_vec() !== 16'h0001) begin
            n_errors++; $display("FAIL areset_halt: got %h expected 0001", dut_vec());
        end
        model_reset();
        @(negedge clk); nreset = 1;
    endtask

    task automatic test_random();
        bit f, h, ie, iq;
        logic [7:0] d;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            f  = ($urandom_range(0, 2) == 0);
            h  = ($urandom_range(0, 11) == 0);
            ie = 1'($urandom);
            iq = ($urandom_range(0, 3) == 0);
            d  = ($urandom_range(0, 7) == 0) ? 8'hCB : 8'($urandom);
            if ($urandom_range(0, 4) == 0) idle();
            else adv(f, d, h, ie, iq);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL random_step %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        clear_inputs();
        model_reset();
        test_reset();
        test_alu();
        test_cb();
        test_int();
        test_halt();
        test_halt_bug();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
